// File: rtl/seg_scan_mux_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// The BCD-to-segment decoder uses DIGIT_W from here as well.
package seg_pkg;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BRIGHT_W   = 3;
  localparam int unsigned PHASES     = 8;
  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned MAX_DIGITS = 8;
  // Common-anode, active-low: every anode high means all digits dark.
  localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = '1;
endpackage

// File: rtl/seg_scan_mux_if.sv
// Digit-vector source to scanner to decoder/anode driver connection.
interface seg_scan_mux_if
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS = 8
);
  logic [DIGIT_W*DIGITS-1:0] digits;
  logic [DIGITS-1:0]         digit_en;
  logic [BRIGHT_W-1:0]       brightness;
  logic [DIGIT_W-1:0]        digit;
  logic [DIGITS-1:0]         an;
  logic [IDX_W-1:0]          digit_idx;
  logic                      frame_tick;

  modport master (
    output digits, digit_en, brightness,
    input  digit, an, digit_idx, frame_tick
  );

  modport slave (
    input  digits, digit_en, brightness,
    output digit, an, digit_idx, frame_tick
  );
endinterface

// File: rtl/seg_scan_mux_refresh_timer.sv
// Slot/phase timebase: div_cnt runs per slot, slot runs per frame, phase is div_cnt/(REFRESH_DIV/8).
module seg_refresh_timer
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  localparam int unsigned SLOT_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [SLOT_W-1:0]  slot,
  output logic [PHASE_W-1:0] phase,
  output logic               slot_start,
  output logic               frame_start
);
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned SUB   = REFRESH_DIV / PHASES;
  localparam int unsigned SUB_W = (SUB > 1) ? $clog2(SUB) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [SUB_W-1:0] sub_cnt;

  // Phase is tracked with its own prescaler instead of dividing div_cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      sub_cnt <= '0;
      phase   <= '0;
      slot    <= '0;
    end else if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
      div_cnt <= '0;
      sub_cnt <= '0;
      phase   <= '0;
      slot    <= (slot == SLOT_W'(DIGITS - 1)) ? '0 : slot + SLOT_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      if (sub_cnt == SUB_W'(SUB - 1)) begin
        sub_cnt <= '0;
        phase   <= phase + PHASE_W'(1);
      end else begin
        sub_cnt <= sub_cnt + SUB_W'(1);
      end
    end
  end

  assign slot_start  = (div_cnt == '0);
  assign frame_start = slot_start && (slot == '0);
endmodule

// File: rtl/seg_scan_mux.sv
// 7-segment digit scanner: frame snapshot, PWM brightness, phase-0 ghosting guard.
// Optional leading-zero blanking with SEG_SCAN_LZB_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic          clk,
  input logic          reset,
  seg_scan_mux_if.slave bus
);
  localparam int unsigned SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SLOT_W-1:0]         slot;
  logic [PHASE_W-1:0]        phase;
  logic                      slot_start;
  logic                      frame_start;
  logic [DIGIT_W*DIGITS-1:0] snap_digits, cur_digits;
  logic [DIGITS-1:0]         snap_en, cur_en, snap_blank, cur_blank, lz_blank, an_next;
  logic [BRIGHT_W-1:0]       bri_q;
  logic [DIGIT_W-1:0]        digit_next;

  seg_refresh_timer #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .slot        (slot),
    .phase       (phase),
    .slot_start  (slot_start),
    .frame_start (frame_start)
  );

`ifdef SEG_SCAN_LZB_EN
  logic seen;
  always_comb begin
    lz_blank = '0;
    seen     = 1'b0;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      if (bus.digits[DIGIT_W*k +: DIGIT_W] != '0) seen = 1'b1;
      if (!seen) lz_blank[k] = 1'b1;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // In the snapshot cycle the registers are not loaded yet, so read the live inputs.
  always_comb begin
    cur_digits = frame_start ? bus.digits   : snap_digits;
    cur_en     = frame_start ? bus.digit_en : snap_en;
    cur_blank  = frame_start ? lz_blank     : snap_blank;
    an_next    = AN_ALL_OFF[DIGITS-1:0];
    digit_next = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (slot == SLOT_W'(k)) begin
        digit_next = cur_digits[DIGIT_W*k +: DIGIT_W];
        if (cur_en[k] && !cur_blank[k] && (phase != '0) && (phase <= bri_q))
          an_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_digits    <= '0;
      snap_en        <= '0;
      snap_blank     <= '0;
      bri_q          <= '0;
      bus.an         <= AN_ALL_OFF[DIGITS-1:0];
      bus.digit      <= '0;
      bus.digit_idx  <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      if (frame_start) begin
        snap_digits <= bus.digits;
        snap_en     <= bus.digit_en;
        snap_blank  <= lz_blank;
      end
      if (slot_start) bri_q <= bus.brightness;
      bus.an         <= an_next;
      bus.digit      <= digit_next;
      bus.digit_idx  <= IDX_W'(slot);
      bus.frame_tick <= frame_start;
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux with DIGITS=4, REFRESH_DIV=16, checked against a cycle-count model.
module tb_seg_scan_mux;
  localparam int unsigned ND = 4;
  localparam int unsigned RD = 16;
  localparam int unsigned FRAME = ND * RD;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seg_scan_mux_if #(.DIGITS(ND)) bus ();

  seg_scan_mux #(
    .DIGITS      (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int oc = 0;
  int lows[ND];

  // Reference state: counters derived from cycles since reset, not from DUT state.
  logic [15:0] m_snap;
  logic [3:0]  m_en, m_blank;
  int          m_bri;
  int unsigned m_n;
  logic [3:0]  e_an, e_digit;
  int          e_idx;
  logic        e_ft;
  bit          m_valid = 1'b0;

  function automatic logic [3:0] lzb_mask(input logic [15:0] d);
    logic [3:0] m;
    int h;
    m = 4'h0;
`ifdef SEG_SCAN_LZB_EN
    h = 0;
    for (int k = 0; k < 4; k++)
      if (((d >> (4 * k)) & 16'hF) != 0) h = k;
    for (int k = 0; k < 4; k++)
      if (k > h) m[k] = 1'b1;
`else
    h = 0;
    if (d == 16'h0) m = 4'h0 | 4'(h);
`endif
    return m;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_n = 0; m_snap = '0; m_en = '0; m_blank = '0; m_bri = 0;
      e_an = 4'hF; e_digit = 4'h0; e_idx = 0; e_ft = 1'b0;
    end else begin
      int dv, sl, ph;
      dv = int'(m_n % RD);
      sl = int'((m_n / RD) % ND);
      ph = dv / (RD / 8);
      if (m_n % FRAME == 0) begin
        m_snap  = bus.digits;
        m_en    = bus.digit_en;
        m_blank = lzb_mask(bus.digits);
      end
      if (dv == 0) m_bri = int'(bus.brightness);
      e_ft    = (m_n % FRAME == 0);
      e_digit = 4'((m_snap >> (4 * sl)) & 16'hF);
      e_idx   = sl;
      e_an    = 4'hF;
      if (m_en[sl] && !m_blank[sl] && ph >= 1 && ph <= m_bri) e_an[sl] = 1'b0;
      m_n++;
    end
    m_valid = 1'b1;
    #1;
    tests++;
    if (bus.an !== e_an || bus.digit !== e_digit || int'(bus.digit_idx) != e_idx ||
        bus.frame_tick !== e_ft) begin
      fails++;
      $display("FAIL model t=%0t an=%b/%b digit=%0d/%0d idx=%0d/%0d tick=%b/%b (dut/expected)",
               $time, bus.an, e_an, bus.digit, e_digit, bus.digit_idx, e_idx,
               bus.frame_tick, e_ft);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task tick();
    @(negedge clk);
    oc++;
  endtask

  task goto(input int t);
    while (oc < t) tick();
  endtask

  task clear_lows();
    for (int b = 0; b < ND; b++) lows[b] = 0;
  endtask

  task count_to(input int t);
    while (oc < t) begin
      tick();
      for (int b = 0; b < ND; b++) if (bus.an[b] == 1'b0) lows[b]++;
    end
  endtask

  initial begin
    bus.digits = 16'h4321; bus.digit_en = 4'hF; bus.brightness = 3'd7;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    oc = 0;

    goto(1);
    check("first frame_tick", int'(bus.frame_tick), 1);
    check("first an", int'(bus.an), 15);
    check("first digit", int'(bus.digit), 1);
    check("first idx", int'(bus.digit_idx), 0);
    goto(2);  check("phase0 dark", int'(bus.an), 15);
    goto(3);  check("slot0 lit start", int'(bus.an), 14);
    goto(16); check("slot0 lit end", int'(bus.an), 14);
    goto(17);
    check("slot1 digit", int'(bus.digit), 2);
    check("slot1 idx", int'(bus.digit_idx), 1);
    check("slot1 boundary dark", int'(bus.an), 15);
    goto(33); check("slot2 digit", int'(bus.digit), 3);
    goto(49); check("slot3 digit", int'(bus.digit), 4);
    goto(64); check("no tick mid frame", int'(bus.frame_tick), 0);
    goto(65);
    check("second frame_tick", int'(bus.frame_tick), 1);
    check("frame2 digit0", int'(bus.digit), 1);

    goto(85); bus.digits = 16'h8765;
    goto(97);  check("tear slot2", int'(bus.digit), 3);
    goto(113); check("tear slot3", int'(bus.digit), 4);
    goto(129); check("new frame d0", int'(bus.digit), 5);
    goto(145); check("new frame d1", int'(bus.digit), 6);
    bus.brightness = 3'd2;

    goto(160); clear_lows(); count_to(176);
    check("bright2 lit cycles", lows[0] + lows[1] + lows[2] + lows[3], 4);
    bus.brightness = 3'd0;
    clear_lows(); count_to(192);
    check("bright0 lit cycles", lows[0] + lows[1] + lows[2] + lows[3], 0);

    bus.brightness = 3'd7; bus.digit_en = 4'b1010;
    clear_lows(); count_to(208);
    check("mask slot0 len", int'(bus.digit_idx), 0);
    count_to(209);
    check("mask slot1 start", int'(bus.digit_idx), 1);
    count_to(256);
    check("mask d0 dark", lows[0], 0);
    check("mask d1 lit", lows[1], 14);
    check("mask d2 dark", lows[2], 0);
    check("mask d3 lit", lows[3], 14);

    bus.digit_en = 4'hF; bus.digits = 16'h0050;
    clear_lows(); count_to(320);
`ifdef SEG_SCAN_LZB_EN
    check("lzb0050 d3", lows[3], 0);
    check("lzb0050 d2", lows[2], 0);
`else
    check("lzb0050 d3", lows[3], 14);
    check("lzb0050 d2", lows[2], 14);
`endif
    check("lzb0050 d1", lows[1], 14);
    check("lzb0050 d0", lows[0], 14);
    bus.digits = 16'h0000;
    clear_lows(); count_to(384);
`ifdef SEG_SCAN_LZB_EN
    check("zero d3", lows[3], 0);
    check("zero d1", lows[1], 0);
`else
    check("zero d3", lows[3], 14);
    check("zero d1", lows[1], 14);
`endif
    check("zero d0", lows[0], 14);

    goto(423); reset = 1'b1;
    tick();
    check("midreset an", int'(bus.an), 15);
    check("midreset idx", int'(bus.digit_idx), 0);
    check("midreset digit", int'(bus.digit), 0);
    check("midreset tick", int'(bus.frame_tick), 0);
    bus.digits = 16'h4321; reset = 1'b0; oc = 0;
    goto(1);
    check("restart tick", int'(bus.frame_tick), 1);
    check("restart digit", int'(bus.digit), 1);
    goto(17); check("restart slot1", int'(bus.digit_idx), 1);

    repeat (800) begin
      tick();
      if ($urandom_range(15) == 0) bus.digits = 16'($urandom);
      if ($urandom_range(23) == 0) bus.digit_en = 4'($urandom);
      if ($urandom_range(19) == 0) bus.brightness = 3'($urandom);
      reset = ($urandom_range(299) == 0);
    end
    reset = 1'b0;
    repeat (FRAME) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed scanner for the 8-digit common-anode 7-segment display. It sits directly upstream of the BCD-to-segment decoder. It takes a packed vector of BCD digits and, one digit at a time, drives the 4-bit decoder input together with the active-low anode enables. Each digit gets an equal refresh slot, with PWM brightness control and a ghosting guard. The digit vector is snapshotted once per frame so the display never tears mid-scan.

## Interface
- `DIGITS`, default 8: number of digit positions, 2..8.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot. Must be a multiple of 8 and at least 16.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `digits`  in  4*DIGITS: packed BCD. Digit k is `[4k+3:4k]`; digit 0 is least significant (rightmost).
- `digit_en`  in  DIGITS: per-digit enable mask. 0 keeps that anode dark for its whole slot.
- `brightness`  in  3: PWM level 0..7. 0 means display off.
- `digit`  out  4: BCD value for the current slot, fed to the decoder input.
- `an`  out  DIGITS: anode enables, active-low. At most one bit is low at any time.
- `digit_idx`  out  3: index of the current slot.
- `frame_tick`  out  1: one-cycle pulse when a new snapshot is taken.

## Operation
- **Counters**
  - `div_cnt` runs 0..REFRESH_DIV-1 and wraps.
  - `slot` increments when `div_cnt` wraps, and wraps from DIGITS-1 to 0.
  - `phase = div_cnt / (REFRESH_DIV/8)`, range 0..7.
- **Snapshot**
  - Loaded in the cycle where `slot==0` and `div_cnt==0`. This includes the first cycle after reset.
  - Holds `digits` and `digit_en` for the entire frame.
  - `frame_tick` pulses in that same cycle.
- **Brightness**
  - `brightness` is latched into `bri_q` when `div_cnt==0` and held for the slot.
- **Anode drive**
  - Anode `slot` is driven low only when all of these hold: the snapshot `digit_en[slot]` is 1, `1 <= phase <= bri_q`, and the digit is not blanked.
  - Phase 0 is always dark (ghosting guard), so the maximum duty is 7/8.
- **Digit output**
  - `digit` equals the snapshot digit `slot` for the entire slot, whether the anode is lit or not.
  - Values 10..15 pass through unmodified.
- **Constant refresh rate**: disabled or blanked digits still consume their slot.
- **Reset**
  - Reset values: `div_cnt=0`, `slot=0`, snapshot all zero, `bri_q=0`, `an` all ones, `digit=0`, `digit_idx=0`, `frame_tick=0`.
  - Reset asserted mid-slot returns everything to these values at the next edge.

## Timing
- `an`, `digit`, `digit_idx` and `frame_tick` are registered, with one cycle of latency from counter state.
  - State at cycle t appears on the outputs at cycle t+1.
- First cycle after `reset` deasserts: counter state is slot 0, `div_cnt` 0, snapshot loads. `frame_tick=1` is visible on the next cycle.
- Slot boundary: `digit_idx` and `digit` change on the same edge. `an` is already all ones at that point because phase 7 of the previous slot ends and phase 0 of the new slot is dark.
- Input changes:
  - `digits` changes mid-frame are invisible until the next snapshot.
  - `brightness` changes mid-slot take effect at the next slot.
- Frame period is `DIGITS*REFRESH_DIV` cycles exactly.

## Configuration
- Macro: `SEG_SCAN_LZB_EN` (leading-zero blanking).
- **Defined**:
  - At snapshot time, find the highest-index digit among the snapshot digits that is non-zero.
  - All enabled digit positions above that index are blanked (`an` stays high).
  - Digit 0 is never blanked. An all-zero value therefore shows a single "0".
- **Undefined**: no blanking. All enabled digits show, including leading zeros.

## Structure
- Package `seg_pkg` holds the shared constants: `DIGIT_W=4`, `BRIGHT_W=3`, `PHASES=8`, and the blank/all-off anode constant.
- The decoder consumes `DIGIT_W` from the same package.
- Sub-module `seg_refresh_timer` holds `div_cnt`, `slot` and `phase`, and emits `slot_start` and `frame_start` strobes.
- The top level holds the snapshot, brightness latch, blanking logic and output registers.

## Test plan
Bench configuration: DIGITS=4, REFRESH_DIV=16 (2 cycles per phase).
- **Reset and scan order**: `reset` 3 cycles, then `digits=16'h4321`, `digit_en=4'hF`, `brightness=7`.
  - `an` is 1111 for the 1st output cycle.
  - Slot 0: `digit=1`; `an=1110` for output cycles 3..16 of the slot.
  - Slots then follow in order 1,2,3 with `digit` 2,3,4.
  - `frame_tick` is high exactly every 64 cycles.
- **Brightness**: `brightness=2`.
  - Anode low for exactly 4 cycles per slot (phases 1..2).
  - `brightness=0` keeps `an=1111` throughout.
- **Tear-free snapshot**: change `digits` from 16'h4321 to 16'h8765 during slot 1.
  - Slots 2 and 3 still show 3 and 4.
  - The next frame shows 5,6,7,8.
- **Mask**: `digit_en=4'b1010`.
  - Anodes for digits 0 and 2 never go low.
  - Their slots still last 16 cycles.
- **Leading-zero blanking**, with `SEG_SCAN_LZB_EN` defined: `digits=16'h0050`.
  - Digits 3 and 2 stay dark; digits 1 and 0 light.
  - `digits=16'h0000` lights digit 0 only.
  - Without the macro, all four light.
- **Reset mid-slot**: assert `reset` at slot 2, `div_cnt=7`.
  - Next edge: `an=1111`, `digit_idx=0`.
  - Scanning restarts at slot 0 with a new snapshot.
